alu_op_sequencer: RTL
=====================

// Module: alu_op_sequencer
// PURPOSE
//  Multi-cycle controller for register-to-register ALU ops on the shared 32-bit datapath bus.
//  Accepts one op per valid/ready handshake and sequences the T-states. Per cycle it drives
//  the bus mux select, the one-hot register load, the Y/Z/HI/LO loads and the ALU opcode.
//  Sits between instruction decode and the bus mux / register file.
// PARAMETERS
//  SEL_ZHIGH  5'b10010  bus select code for Zhigh
//  SEL_ZLOW   5'b10011  bus select code for Zlow
//  SEL_IMM    5'b11000  bus select code for sign-extended C immediate
//  SEL_IDLE   5'b11111  bus select in idle (unmapped code, so the bus reads 0)
//  OP_MUL     5'b10000  opcode whose result goes to HI/LO
//  OP_DIV     5'b01111  opcode whose result goes to HI/LO
//  OP_NEG     5'b10001  unary opcode (no Y load)
//  OP_NOT     5'b10010  unary opcode (no Y load)
// PORTS
//  clock        in   1   rising-edge clock
//  clear_n      in   1   asynchronous active-low reset
//  req_valid    in   1   op request valid
//  req_ready    out  1   sequencer can accept (1 only in IDLE)
//  req_opcode   in   5   ALU opcode
//  req_ra       in   4   destination register
//  req_rb       in   4   source A register
//  req_rc       in   4   source B register (ignored when req_imm=1)
//  req_imm      in   1   source B is the C immediate
//  abort        in   1   synchronous cancel of the op in flight
//  data_select  out  5   bus mux select
//  r_in         out  16  one-hot register-file load enable
//  y_in         out  1   Y register load
//  z_in         out  1   Z register load
//  hi_in        out  1   HI register load
//  lo_in        out  1   LO register load
//  alu_op       out  5   opcode presented to ALU (latched op; 0 in IDLE)
//  busy         out  1   op in flight (state != IDLE)
//  done         out  1   1-cycle pulse in final write cycle
// BEHAVIOUR
//  - Reset: state=IDLE; latched op/ra/rb/rc/imm=0; data_select=SEL_IDLE.
//    All enables, done and busy=0; req_ready=1.
//  - Accept: req_valid&&req_ready at a rising edge latches all req_* fields.
//    Moore outputs decode from state plus latched fields only.
//  - States and per-cycle outputs:
//    IDLE: no loads. Binary op -> TY; unary op -> TZ; otherwise hold.
//    TY: data_select=rb, y_in=1. -> TZ.
//    TZ: data_select = SEL_IMM if imm, else rc; for unary ops, rb. z_in=1, alu_op=op.
//        -> TLO if MUL/DIV, else TW.
//    TW: data_select=SEL_ZLOW, r_in=1<<ra, done=1. -> IDLE.
//    TLO: data_select=SEL_ZLOW, lo_in=1. -> THI.
//    THI: data_select=SEL_ZHIGH, hi_in=1, done=1. -> IDLE. ra is unused for MUL/DIV.
//  - Latency from accept edge to done cycle: binary 3 cycles, unary 2, MUL/DIV 4.
//  - Throughput: req_ready is 0 from accept until the cycle after done.
//    Back-to-back ops therefore have one IDLE bubble.
//  - alu_op holds the latched opcode in every non-IDLE state.
//  - abort=1 in a non-IDLE state combinationally forces all loads and done to 0 that cycle.
//    The next state is IDLE. abort in IDLE is ignored.
//  - req_valid while busy is ignored. Fields do not change mid-op.
//  - clear_n low mid-op: immediate return to IDLE. No partial write completes after release.
//  - r_in is always one-hot or zero. Writing R0 is legal, with no special handling.
// TESTING
//  1 add R3,R1,R2: TY sel=1 y_in; TZ sel=2 z_in alu_op=00011; TW sel=19 r_in=0x0008 done.
//  2 mul R5,R6: sel 5,6; TLO sel=19 lo_in; THI sel=18 hi_in done; r_in stays 0; 4 cycles.
//  3 neg R7,R4: TZ sel=4 z_in (no y_in); TW r_in=0x0080 done; ready again next cycle.
//  4 addi R2,R1,imm: TZ sel=24. Hold req_valid during op: exactly one op executes.
//  5 abort in TZ: no z_in that cycle; IDLE next; no r_in/done. Next op then runs normally.
//  6 clear_n low in TLO: outputs at reset values at once; after release ready=1, no hi_in.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Multi-cycle T-state controller for register-to-register ALU ops on the shared datapath bus.
// Drives bus select, register/Y/Z/HI/LO loads and the ALU opcode for one op at a time.
//
// state | meaning
// IDLE  | waiting for a request; bus reads the unmapped select
// TY    | source A (rb) onto the bus, load Y
// TZ    | source B (rc / immediate, or rb for unary ops) onto the bus, ALU result into Z
// TW    | Zlow written back to ra; done
// TLO   | Zlow into LO (MUL/DIV)
// THI   | Zhigh into HI; done (MUL/DIV)
module alu_op_sequencer #(
    parameter logic [4:0] SEL_ZHIGH = 5'b10010,
    parameter logic [4:0] SEL_ZLOW  = 5'b10011,
    parameter logic [4:0] SEL_IMM   = 5'b11000,
    parameter logic [4:0] SEL_IDLE  = 5'b11111,
    parameter logic [4:0] OP_MUL    = 5'b10000,
    parameter logic [4:0] OP_DIV    = 5'b01111,
    parameter logic [4:0] OP_NEG    = 5'b10001,
    parameter logic [4:0] OP_NOT    = 5'b10010
) (
    input  logic        clock,
    input  logic        clear_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_opcode,
    input  logic [3:0]  req_ra,
    input  logic [3:0]  req_rb,
    input  logic [3:0]  req_rc,
    input  logic        req_imm,
    input  logic        abort,
    output logic [4:0]  data_select,
    output logic [15:0] r_in,
    output logic        y_in,
    output logic        z_in,
    output logic        hi_in,
    output logic        lo_in,
    output logic [4:0]  alu_op,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TY,
        S_TZ,
        S_TW,
        S_TLO,
        S_THI
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [4:0] op_q;
    logic [3:0] ra_q;
    logic [3:0] rb_q;
    logic [3:0] rc_q;
    logic       imm_q;
    logic       accept;
    logic       req_unary;
    logic       op_unary;
    logic       op_muldiv;

    assign accept    = req_valid && (state == S_IDLE);
    assign req_unary = (req_opcode == OP_NEG) || (req_opcode == OP_NOT);
    assign op_unary  = (op_q == OP_NEG) || (op_q == OP_NOT);
    assign op_muldiv = (op_q == OP_MUL) || (op_q == OP_DIV);

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state <= S_IDLE;
            op_q  <= 5'd0;
            ra_q  <= 4'd0;
            rb_q  <= 4'd0;
            rc_q  <= 4'd0;
            imm_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q  <= req_opcode;
                ra_q  <= req_ra;
                rb_q  <= req_rb;
                rc_q  <= req_rc;
                imm_q <= req_imm;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        data_select = SEL_IDLE;
        r_in        = 16'd0;
        y_in        = 1'b0;
        z_in        = 1'b0;
        hi_in       = 1'b0;
        lo_in       = 1'b0;
        alu_op      = 5'd0;
        done        = 1'b0;
        req_ready   = (state == S_IDLE);
        busy        = (state != S_IDLE);

        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    state_nxt = req_unary ? S_TZ : S_TY;
                end
            end
            S_TY: begin
                data_select = {1'b0, rb_q};
                y_in        = 1'b1;
                alu_op      = op_q;
                state_nxt   = S_TZ;
            end
            S_TZ: begin
                if (op_unary) begin
                    data_select = {1'b0, rb_q};
                end else if (imm_q) begin
                    data_select = SEL_IMM;
                end else begin
                    data_select = {1'b0, rc_q};
                end
                z_in      = 1'b1;
                alu_op    = op_q;
                state_nxt = op_muldiv ? S_TLO : S_TW;
            end
            S_TW: begin
                data_select = SEL_ZLOW;
                r_in        = 16'd1 << ra_q;
                alu_op      = op_q;
                done        = 1'b1;
                state_nxt   = S_IDLE;
            end
            S_TLO: begin
                data_select = SEL_ZLOW;
                lo_in       = 1'b1;
                alu_op      = op_q;
                state_nxt   = S_THI;
            end
            S_THI: begin
                data_select = SEL_ZHIGH;
                hi_in       = 1'b1;
                alu_op      = op_q;
                done        = 1'b1;
                state_nxt   = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Abort only suppresses side effects; select and opcode stay visible for that cycle.
        if (abort && (state != S_IDLE)) begin
            r_in      = 16'd0;
            y_in      = 1'b0;
            z_in      = 1'b0;
            hi_in     = 1'b0;
            lo_in     = 1'b0;
            done      = 1'b0;
            state_nxt = S_IDLE;
        end
    end

endmodule
